// File: rtl/mmult_rr_arbiter.sv
// Round-robin arbiter/sequencer sharing one matrix-multiply core between NUM_REQ requesters.
// Optional watchdog enabled by defining ARB_TIMEOUT_EN.
module mmult_rr_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int SEL_WIDTH      = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   start_in,
  output logic [NUM_REQ-1:0]   grant,
  output logic [SEL_WIDTH-1:0] core_sel,
  output logic                 core_start,
  input  logic                 core_done,
  output logic [NUM_REQ-1:0]   done_out,
  output logic                 busy,
  output logic                 timeout_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    RUN     = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [SEL_WIDTH-1:0] sel_q, sel_d;
  logic [SEL_WIDTH-1:0] last_q, last_d;
  logic                 start_q, start_d;
  logic                 busy_q, busy_d;
  logic                 to_q, to_d;

  logic [SEL_WIDTH-1:0] pick_s;
  logic                 pick_vld_s;
  int                   dist_s;
  int                   best_s;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  // Watchdog limit has no effect when the counter is not built.
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  // Pick the set req bit with the smallest rotated distance after the last winner.
  always_comb begin
    pick_s     = '0;
    pick_vld_s = |req;
    dist_s     = 0;
    best_s     = NUM_REQ;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req[i]) begin
        dist_s = (i + NUM_REQ - 1 - int'(last_q)) % NUM_REQ;
        if (dist_s < best_s) begin
          best_s = dist_s;
          pick_s = SEL_WIDTH'(i);
        end else begin
          best_s = best_s;
        end
      end else begin
        dist_s = dist_s;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    last_d  = last_q;
    busy_d  = busy_q;
    start_d = 1'b0;
    done_d  = '0;
    to_d    = 1'b0;
`ifdef ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_vld_s) begin
          state_d = GRANTED;
          grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_s;
          sel_d   = pick_s;
          last_d  = pick_s;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      GRANTED: begin
        // A withdrawal beats a simultaneous start.
        if (!(|(req & grant_q))) begin
          state_d = IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
        end else if (|(start_in & grant_q)) begin
          state_d = RUN;
          start_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else begin
          state_d = GRANTED;
        end
      end
      RUN: begin
        if (core_done) begin
          state_d = IDLE;
          done_d  = grant_q;
          grant_d = '0;
          busy_d  = 1'b0;
`ifdef ARB_TIMEOUT_EN
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = IDLE;
          to_d    = 1'b1;
          grant_d = '0;
          busy_d  = 1'b0;
        end else begin
          cnt_d   = cnt_q + 1'b1;
`else
        end else begin
          state_d = RUN;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      last_q  <= SEL_WIDTH'(NUM_REQ - 1);
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      done_q  <= '0;
      to_q    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      start_q <= start_d;
      done_q  <= done_d;
      to_q    <= to_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign grant       = grant_q;
  assign core_sel    = sel_q;
  assign core_start  = start_q;
  assign done_out    = done_q;
  assign busy        = busy_q;
  assign timeout_err = to_q;

endmodule

// File: tb/tb_mmult_rr_arbiter.sv
// Self-checking bench for mmult_rr_arbiter: vector table, directed corner sequences,
// and randomized traffic against a behavioural model.
module tb_mmult_rr_arbiter;

  localparam int N = 4;
  localparam int SW = 2;
`ifdef ARB_TIMEOUT_EN
  localparam int TO = 16;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TO = 1024;
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req, start_in, grant, done_out;
  logic [SW-1:0] core_sel;
  logic          core_start, core_done, busy, timeout_err;

  int checks = 0;
  int errors = 0;

  mmult_rr_arbiter #(.NUM_REQ(N), .SEL_WIDTH(SW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .start_in(start_in), .grant(grant),
    .core_sel(core_sel), .core_start(core_start), .core_done(core_done),
    .done_out(done_out), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; start_in = '0; core_done = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // One full service of the currently granted requester, ending on the arbitration edge.
  task automatic serve(input logic [N-1:0] eg);
    chk("rr_grant", grant, eg);
    chk("rr_busy", busy, 1);
    start_in = eg;
    tick();
    start_in = '0;
    chk("rr_start", core_start, 1);
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    chk("rr_start_off", core_start, 0);
    chk("rr_done", done_out, eg);
    chk("rr_gap", grant, 0);
    tick();
  endtask

  typedef struct {
    logic [N-1:0]  r;
    logic [N-1:0]  s;
    logic          d;
    logic [N-1:0]  eg;
    logic [SW-1:0] esel;
    logic          es;
    logic [N-1:0]  ed;
  } vec_t;
  vec_t tbl[12];

  // Behavioural model state
  int m_owner, m_last, m_cnt;
  bit m_run;
  logic m_start, m_to;
  logic [N-1:0] m_done;

  task automatic model(input logic [N-1:0] r, input logic [N-1:0] s, input logic d);
    m_start = 1'b0; m_done = '0; m_to = 1'b0;
    if (m_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        int ii;
        ii = (m_last + k) % N;
        if (m_owner < 0 && r[ii]) begin
          m_owner = ii; m_last = ii; m_run = 1'b0;
        end
      end
    end else if (!m_run) begin
      if (!r[m_owner]) m_owner = -1;
      else if (s[m_owner]) begin m_run = 1'b1; m_start = 1'b1; m_cnt = 0; end
    end else begin
      if (d) begin m_done = 4'b0001 << m_owner; m_owner = -1; end
      else if (TO_EN && m_cnt == TO - 1) begin m_to = 1'b1; m_owner = -1; end
      else m_cnt++;
    end
  endtask

  initial begin
    logic [N-1:0] r, s, eg;
    logic d;

    // Single-requester transaction with spurious inputs folded in
    tbl[0]  = '{4'b0001, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b0, 4'b0000};
    tbl[1]  = '{4'b0001, 4'b0100, 1'b1, 4'b0001, 2'd0, 1'b0, 4'b0000};
    tbl[2]  = '{4'b0001, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 4'b0000};
    tbl[3]  = '{4'b0001, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b0, 4'b0000};
    tbl[4]  = '{4'b0001, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b0, 4'b0000};
    tbl[5]  = '{4'b0001, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0, 4'b0000};
    tbl[6]  = '{4'b0000, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b0, 4'b0000};
    tbl[7]  = '{4'b0001, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b0, 4'b0000};
    tbl[8]  = '{4'b0001, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b0, 4'b0000};
    tbl[9]  = '{4'b0001, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b0, 4'b0000};
    tbl[10] = '{4'b0001, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 4'b0001};
    tbl[11] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 4'b0000};

    do_reset();
    chk("rst_grant", grant, 0);
    chk("rst_sel", core_sel, 0);
    chk("rst_start", core_start, 0);
    chk("rst_done", done_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_to", timeout_err, 0);

    for (int i = 0; i < 12; i++) begin
      req = tbl[i].r; start_in = tbl[i].s; core_done = tbl[i].d;
      tick();
      chk($sformatf("vec%0d_grant", i), grant, tbl[i].eg);
      chk($sformatf("vec%0d_busy", i), busy, |tbl[i].eg);
      chk($sformatf("vec%0d_start", i), core_start, tbl[i].es);
      chk($sformatf("vec%0d_done", i), done_out, tbl[i].ed);
      if (tbl[i].eg != 0) chk($sformatf("vec%0d_sel", i), core_sel, tbl[i].esel);
    end

    // Round-robin with all requesters held
    do_reset();
    req = 4'b1111;
    tick();
    serve(4'b0001); serve(4'b0010); serve(4'b0100); serve(4'b1000); serve(4'b0001);

    // Wrap and skip after serving requester 2
    do_reset();
    req = 4'b0100;
    tick();
    chk("wrap_grant2", grant, 4'b0100);
    start_in = 4'b0100; tick(); start_in = '0;
    core_done = 1'b1; req = 4'b0011; tick(); core_done = 1'b0;
    chk("wrap_done", done_out, 4'b0100);
    tick();
    chk("wrap_grant0", grant, 4'b0001);
    chk("wrap_sel", core_sel, 0);

    // Early withdrawal, pending requester 3 served next
    do_reset();
    req = 4'b0010;
    tick();
    chk("wd_grant1", grant, 4'b0010);
    chk("wd_sel1", core_sel, 1);
    req = 4'b1000; start_in = 4'b0010;
    tick();
    start_in = '0;
    chk("wd_release", grant, 0);
    chk("wd_nostart", core_start, 0);
    tick();
    chk("wd_grant3", grant, 4'b1000);
    chk("wd_sel3", core_sel, 3);
    chk("wd_nostart2", core_start, 0);

    // Reset asserted during RUN
    do_reset();
    req = 4'b0100; tick();
    start_in = 4'b0100; tick(); start_in = '0;
    chk("rr_run_start", core_start, 1);
    rst = 1'b1; req = 4'b1111; core_done = 1'b1;
    tick();
    rst = 1'b0; core_done = 1'b0;
    chk("rrun_grant", grant, 0);
    chk("rrun_done", done_out, 0);
    chk("rrun_start", core_start, 0);
    chk("rrun_busy", busy, 0);
    chk("rrun_sel", core_sel, 0);
    tick();
    chk("rrun_prio0", grant, 4'b0001);

`ifdef ARB_TIMEOUT_EN
    // Watchdog fires 16 cycles after RUN entry
    do_reset();
    req = 4'b0001; tick();
    start_in = 4'b0001; tick(); start_in = '0;
    for (int i = 1; i < TO; i++) begin
      tick();
      chk("to_wait_err", timeout_err, 0);
      chk("to_wait_grant", grant, 4'b0001);
    end
    tick();
    chk("to_err", timeout_err, 1);
    chk("to_grant", grant, 0);
    chk("to_nodone", done_out, 0);
    tick();
    chk("to_err_pulse", timeout_err, 0);
    chk("to_next_grant", grant, 4'b0001);

    // Done on the final cycle beats the watchdog
    start_in = 4'b0001; tick(); start_in = '0;
    for (int i = 1; i < TO; i++) tick();
    core_done = 1'b1; tick(); core_done = 1'b0;
    chk("tod_done", done_out, 4'b0001);
    chk("tod_noerr", timeout_err, 0);
    chk("tod_grant", grant, 0);
`endif

    // Randomized traffic against the model
    do_reset();
    m_owner = -1; m_last = N - 1; m_run = 1'b0; m_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      r = N'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) r = r | req;
      s = N'($urandom_range(0, 15));
      d = ($urandom_range(0, 4) == 0);
      req = r; start_in = s; core_done = d;
      model(r, s, d);
      tick();
      eg = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
      chk("rnd_grant", grant, eg);
      chk("rnd_busy", busy, (m_owner >= 0));
      chk("rnd_start", core_start, m_start);
      chk("rnd_done", done_out, m_done);
      chk("rnd_to", timeout_err, m_to);
      if (m_owner >= 0) chk("rnd_sel", core_sel, m_owner);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmult_rr_arbiter.md
Name: mmult_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one simple_generic_matrix_mult core between NUM_REQ requesters, e.g. several graphics_transform pipelines.
- Grants the core to one requester at a time and forwards that requester's start to the core as a single-cycle pulse.
- Returns the core's done to the granted requester, then releases the grant.
- Drives the select for the external operand/result mux.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- SEL_WIDTH, 2, width of core_sel; must be at least ceil(log2(NUM_REQ)).
- TIMEOUT_CYCLES, 1024, watchdog limit in cycles; used only with ARB_TIMEOUT_EN.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester request level; held high while the requester wants the core.
- start_in  input  NUM_REQ  per-requester start; only the granted bit is honoured.
- grant  output  NUM_REQ  one-hot grant, registered.
- core_sel  output  SEL_WIDTH  binary index of the granted requester; drives the operand/result mux.
- core_start  output  1  single-cycle start pulse to the matrix core.
- core_done  input  1  done pulse from the matrix core.
- done_out  output  NUM_REQ  single-cycle completion pulse to the granted requester.
- busy  output  1  high whenever any grant is active.
- timeout_err  output  1  watchdog error pulse; tied 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; grant=0, core_sel=0, core_start=0, done_out=0, busy=0, timeout_err=0.
  - last-grant pointer resets to NUM_REQ-1, so requester 0 has highest priority first.
  - Reset asserted mid-transaction aborts it silently: no done_out, no core_start.
- States: IDLE, GRANTED, RUN.
- IDLE, no req: stay in IDLE.
- IDLE, any req:
  - Choose the first set req bit scanning upward from (last+1) mod NUM_REQ, with wrap-around.
  - On the next edge: grant, core_sel and busy set; pointer updated to the winner; go to GRANTED.
  - Latency from req high to grant high is 1 cycle.
- GRANTED:
  - start_in[sel]=1 and req[sel]=1: core_start pulses high for exactly 1 cycle (registered, so 1 cycle after start_in is sampled); go to RUN.
  - req[sel] drops before start_in: clear grant/busy, go to IDLE. No core_start is issued.
  - start_in and a req drop in the same cycle: the drop wins.
- RUN:
  - Wait for core_done. On core_done: done_out[sel] pulses 1 cycle, grant/busy clear on the same edge, go to IDLE.
  - req changes and start_in are ignored in RUN. The requester must hold its operands until done_out.
- Arbitration gap: at least one idle cycle between consecutive grants, because IDLE always re-arbitrates.
  - A requester that keeps req high is re-granted only after the other active requesters have each had a turn.
- Ignored inputs:
  - core_done outside RUN.
  - start_in bits of non-granted requesters in any state.
- Invariants:
  - grant is one-hot or zero.
  - core_sel is stable for the whole grant.
  - core_start and done_out never assert in the same cycle.
- req bits at or above NUM_REQ do not exist. core_sel upper bits are 0 when SEL_WIDTH exceeds the need.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to RUN and increments each RUN cycle.
  - If it reaches TIMEOUT_CYCLES without core_done: timeout_err pulses 1 cycle, grant/busy clear, go to IDLE, and no done_out is issued.
  - The pointer still advances, so the hung requester loses priority.
  - core_done arriving in the same cycle as the timeout: the done wins, and no error is raised.
- Not defined: no counter is built, timeout_err is constant 0, and RUN waits indefinitely.

Test Plan:
- Single requester: req=4'b0001 at cycle 0 -> grant=0001 and core_sel=0 at cycle 1. start_in[0] at cycle 2 -> core_start=1 at cycle 3 only. core_done at cycle 10 -> done_out=0001 at cycle 11, grant=0 at cycle 11.
- Round-robin: req=4'b1111 held, each grant completed -> grant sequence 0001,0010,0100,1000,0001, with exactly one idle cycle between grants.
- Wrap and skip: after requester 2 is served, req=4'b0011 -> next grant=0001, not 0010.
- Early withdrawal: requester 1 granted, req[1] drops before start_in -> grant=0 next cycle, core_start never asserts, requester 3 (pending) granted on the following arbitration.
- Spurious inputs: start_in[2]=1 while requester 0 is granted, and core_done in IDLE -> no core_start, no done_out, state unchanged. Reset asserted in RUN -> all outputs 0 the next cycle, and requester 0 has top priority.
- ARB_TIMEOUT_EN with TIMEOUT_CYCLES=16: core_done withheld -> timeout_err pulse 16 cycles after RUN entry, grant cleared, no done_out. Repeat with core_done on the 16th cycle -> done_out, no timeout_err.
